conv_cntrl_lb_seq: RTL and testbench

Line-buffer sequencer for the convolution front end: accepts the raster pixel stream and issues push/pop/sol/eol commands to `LB_N` rotating line-buffer controllers (`conv_cntrl_lb_asic` instances). It collects their `colD_o` outputs into an `LB_N`-row window column, ordered oldest row first, and presents it on a valid/ready stream to the kernel datapath. Credit-based flow control keeps the line buffers' fixed pop pipeline from ever being stalled by the downstream consumer.

---
 rtl/conv_cntrl_lb_seq.sv | 205 ++++++++++++++++++++
 tb/tb_conv_cntrl_lb_seq.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_cntrl_lb_seq.sv
// Line-buffer sequencer: steers the raster pixel stream into LB_N rotating line buffers
// and assembles their pop data into oldest-row-first window columns behind a credit-guarded FIFO.
package conv_pkg;
  parameter int PIXEL_W     = 8;
  parameter int IMAGE_MAX_W = 16;
endpackage

// state | meaning
// IDLE  | waiting for sof, other pixels dropped
// FILL  | pushing the first LB_N-1 lines, no output
// RUN   | push live line, pop the others, one window column per pixel
module conv_cntrl_lb_seq #(
  parameter int LB_N   = 4,
  parameter int OQ_N   = 4,
  parameter int LB_LAT = 2
) (
  input  logic                                   clk,
  input  logic                                   arst_n,
  input  logic                                   s_vld_i,
  output logic                                   s_rdy_o,
  input  logic [conv_pkg::PIXEL_W-1:0]           s_dat_i,
  input  logic                                   s_sof_i,
  input  logic                                   s_eol_i,
  input  logic                                   s_eof_i,
  output logic [LB_N-1:0]                        lb_push_o,
  output logic [LB_N-1:0]                        lb_pop_o,
  output logic                                   lb_sol_o,
  output logic                                   lb_eol_o,
  output logic [conv_pkg::PIXEL_W-1:0]           lb_dat_o,
  input  logic [LB_N-1:0][conv_pkg::PIXEL_W-1:0] lb_dat_i,
  output logic                                   m_vld_o,
  input  logic                                   m_rdy_i,
  output logic [LB_N-1:0][conv_pkg::PIXEL_W-1:0] m_dat_o,
  output logic                                   m_sol_o,
  output logic                                   m_eol_o,
  output logic                                   m_eof_o,
  output logic                                   err_o
);
  localparam int PW   = conv_pkg::PIXEL_W;
  localparam int CW   = $clog2(conv_pkg::IMAGE_MAX_W);
  localparam int LW   = $clog2(LB_N);
  localparam int PTRW = (OQ_N > 1) ? $clog2(OQ_N) : 1;
  localparam int OCW  = $clog2(OQ_N + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(conv_pkg::IMAGE_MAX_W - 1);
  localparam logic [LB_N-1:0] SEL_FIRST = {{(LB_N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_RUN} state_t;
  typedef struct packed {
    logic [PW-1:0]   pix;
    logic [LB_N-1:0] sel;
    logic            sol;
    logic            eol;
    logic            eof;
  } pipe_t;
  typedef struct packed {
    logic [LB_N-1:0][PW-1:0] dat;
    logic                    sol;
    logic                    eol;
    logic                    eof;
  } oq_t;

  state_t          state_q, state_d, eff_state;
  logic [LB_N-1:0] wr_sel_q, wr_sel_d, eff_sel;
  logic [LW-1:0]   lines_q, lines_d, eff_lines;
  logic [CW-1:0]   col_q, col_d;
  logic            ovf_q, ovf_d, err_q, err_d;
  logic [LB_LAT-1:0] pv_q, pv_d;
  pipe_t           pd_q [LB_LAT];
  pipe_t           pd_d [LB_LAT];
  oq_t             mem_q [OQ_N];
  oq_t             mem_d [OQ_N];
  logic [PTRW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [OCW-1:0]  occ_q, occ_d;

  logic  acc, sof, proc, force_eol, run_px, credit_ok, oq_wr, oq_rd;
  int    inflight;
  oq_t   wr_ent, head;

  always_comb begin
    inflight = 0;
    for (int i = 0; i < LB_LAT; i++) if (pv_q[i]) inflight++;
    credit_ok = (int'(occ_q) + inflight) < OQ_N;
    s_rdy_o = 1'b1;
    // the line that ends FILL must already respect credit, its successor pops immediately
    if (state_q == ST_RUN || (state_q == ST_FILL && lines_q == LW'(LB_N - 2)))
      s_rdy_o = credit_ok;
  end

  always_comb begin
    acc       = s_vld_i & s_rdy_o & arst_n;
    sof       = acc & s_sof_i;
    eff_state = sof ? ST_FILL : state_q;
    eff_sel   = sof ? SEL_FIRST : wr_sel_q;
    eff_lines = sof ? '0 : lines_q;
    proc      = acc & (eff_state != ST_IDLE) & (sof | ~ovf_q);
    force_eol = proc & ~sof & ~s_eol_i & (col_q == COL_LAST);
    run_px    = proc & (eff_state == ST_RUN);
    lb_push_o = proc ? eff_sel : '0;
    lb_pop_o  = run_px ? ~eff_sel : '0;
    lb_sol_o  = proc & (sof | (col_q == '0));
    lb_eol_o  = proc & (s_eol_i | force_eol);
    lb_dat_o  = s_dat_i;
  end

  always_comb begin
    state_d  = state_q;
    wr_sel_d = wr_sel_q;
    lines_d  = lines_q;
    col_d    = col_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    if (acc && eff_state != ST_IDLE) begin
      state_d  = eff_state;
      wr_sel_d = eff_sel;
      lines_d  = eff_lines;
      ovf_d    = ovf_q & ~sof;
      if (s_eol_i) begin
        col_d    = '0;
        ovf_d    = 1'b0;
        wr_sel_d = {eff_sel[LB_N-2:0], eff_sel[LB_N-1]};
        if (eff_state == ST_FILL) begin
          lines_d = eff_lines + LW'(1);
          if (lines_d == LW'(LB_N - 1)) state_d = ST_RUN;
        end
        if (s_eof_i) state_d = ST_IDLE;
      end else if (proc) begin
        col_d = sof ? CW'(1) : (force_eol ? col_q : col_q + CW'(1));
        if (force_eol) begin
          ovf_d = 1'b1;
          err_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    int w;
    pv_d[0]     = run_px;
    pd_d[0].pix = s_dat_i;
    pd_d[0].sel = eff_sel;
    pd_d[0].sol = lb_sol_o;
    pd_d[0].eol = lb_eol_o;
    pd_d[0].eof = s_eof_i & proc;
    for (int i = 1; i < LB_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    w = 0;
    for (int b = 0; b < LB_N; b++) if (pd_q[LB_LAT-1].sel[b]) w = b;
    wr_ent.dat[LB_N-1] = pd_q[LB_LAT-1].pix;
    // walk backwards from the live buffer so index 0 ends up as the oldest row
    for (int k = 1; k < LB_N; k++)
      wr_ent.dat[LW'(LB_N - 1 - k)] = lb_dat_i[LW'((w - k + LB_N) % LB_N)];
    wr_ent.sol = pd_q[LB_LAT-1].sol;
    wr_ent.eol = pd_q[LB_LAT-1].eol;
    wr_ent.eof = pd_q[LB_LAT-1].eof;
    oq_wr = pv_q[LB_LAT-1];
  end

  always_comb begin
    m_vld_o = (occ_q != '0);
    oq_rd   = m_vld_o & m_rdy_i;
    mem_d   = mem_q;
    if (oq_wr) mem_d[wp_q] = wr_ent;
    wp_d  = oq_wr ? ((wp_q == PTRW'(OQ_N - 1)) ? '0 : wp_q + PTRW'(1)) : wp_q;
    rp_d  = oq_rd ? ((rp_q == PTRW'(OQ_N - 1)) ? '0 : rp_q + PTRW'(1)) : rp_q;
    occ_d = occ_q + OCW'(oq_wr) - OCW'(oq_rd);
    head  = m_vld_o ? mem_q[rp_q] : '0;
    m_dat_o = head.dat;
    m_sol_o = head.sol;
    m_eol_o = head.eol;
    m_eof_o = head.eof;
    err_o   = err_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_IDLE;
      wr_sel_q <= SEL_FIRST;
      lines_q  <= '0;
      col_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      pv_q     <= '0;
      for (int i = 0; i < LB_LAT; i++) pd_q[i] <= '0;
      for (int i = 0; i < OQ_N; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_sel_q <= wr_sel_d;
      lines_q  <= lines_d;
      col_q    <= col_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      pv_q     <= pv_d;
      pd_q     <= pd_d;
      mem_q    <= mem_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      occ_q    <= occ_d;
    end
  end
endmodule

// File: tb/tb_conv_cntrl_lb_seq.sv
// Scoreboard bench for conv_cntrl_lb_seq with a behavioural line-buffer model on lb_*.
module tb_conv_cntrl_lb_seq;
  localparam int LB_N = 4;
  localparam int OQ_N = 4;
  localparam int LB_LAT = 2;
  localparam int PW = conv_pkg::PIXEL_W;
  localparam int MAXW = conv_pkg::IMAGE_MAX_W;

  typedef struct packed {
    logic [LB_N-1:0][PW-1:0] dat;
    logic sol;
    logic eol;
    logic eof;
  } exp_t;

  logic clk = 1'b0;
  logic arst_n;
  logic s_vld_i, s_rdy_o, s_sof_i, s_eol_i, s_eof_i;
  logic [PW-1:0] s_dat_i;
  logic [LB_N-1:0] lb_push_o, lb_pop_o;
  logic lb_sol_o, lb_eol_o;
  logic [PW-1:0] lb_dat_o;
  logic [LB_N-1:0][PW-1:0] lb_dat_i;
  logic m_vld_o, m_rdy_i, m_sol_o, m_eol_o, m_eof_o, err_o;
  logic [LB_N-1:0][PW-1:0] m_dat_o;

  always #5 clk = ~clk;

  conv_cntrl_lb_seq #(.LB_N(LB_N), .OQ_N(OQ_N), .LB_LAT(LB_LAT)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_vld_i(s_vld_i), .s_rdy_o(s_rdy_o), .s_dat_i(s_dat_i),
    .s_sof_i(s_sof_i), .s_eol_i(s_eol_i), .s_eof_i(s_eof_i),
    .lb_push_o(lb_push_o), .lb_pop_o(lb_pop_o), .lb_sol_o(lb_sol_o),
    .lb_eol_o(lb_eol_o), .lb_dat_o(lb_dat_o), .lb_dat_i(lb_dat_i),
    .m_vld_o(m_vld_o), .m_rdy_i(m_rdy_i), .m_dat_o(m_dat_o),
    .m_sol_o(m_sol_o), .m_eol_o(m_eol_o), .m_eof_o(m_eof_o), .err_o(err_o)
  );

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int rdy_mode = 0;
  int rcyc = 0;
  logic saw_stall = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] px(input int base, input int r, input int c);
    return PW'(base + r * 16 + c);
  endfunction

  // line-buffer model: shared column counter, pop data returned LB_LAT cycles later
  logic [PW-1:0] lbm [LB_N][MAXW];
  int mcol = 0;
  logic [LB_N-1:0][PW-1:0] d0 = '0, d1 = '0;
  always @(negedge clk) begin
    logic [LB_N-1:0][PW-1:0] rd;
    if (lb_push_o != '0) begin
      mcol = lb_sol_o ? 0 : mcol + 1;
      for (int b = 0; b < LB_N; b++)
        if (lb_push_o[b] && mcol < MAXW) lbm[b][mcol] = lb_dat_o;
    end
    for (int b = 0; b < LB_N; b++)
      rd[b] = (lb_pop_o[b] && mcol < MAXW) ? lbm[b][mcol] : '0;
    lb_dat_i = d1;
    d1 = d0;
    d0 = rd;
  end

  always @(negedge clk) begin
    exp_t e;
    if (arst_n && s_vld_i && !s_rdy_o) saw_stall = 1'b1;
    if (arst_n && m_vld_o && m_rdy_i) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_output: got m_dat %0h, expected no output", m_dat_o);
      end else begin
        e = sb.pop_front();
        chk("out_dat", 64'(m_dat_o), 64'(e.dat));
        chk("out_sol_eol_eof", {m_sol_o, m_eol_o, m_eof_o}, {e.sol, e.eol, e.eof});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    rcyc++;
    case (rdy_mode)
      0: m_rdy_i = 1'b1;
      1: m_rdy_i = (rcyc % 4 == 0) || (rcyc % 4 == 3);
      default: m_rdy_i = 1'b0;
    endcase
  end

  task automatic send_px(input logic [PW-1:0] d, input logic sof, input logic eol, input logic eof,
                         input logic [LB_N-1:0] e_push, input logic [LB_N-1:0] e_pop,
                         input logic e_eol, input logic must_rdy);
    int waited;
    waited = 0;
    s_vld_i = 1'b1; s_dat_i = d; s_sof_i = sof; s_eol_i = eol; s_eof_i = eof;
    @(negedge clk);
    if (must_rdy) chk("fill_rdy", s_rdy_o, 1);
    while (!s_rdy_o && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!s_rdy_o) begin
      n_chk++;
      $display("FAIL accept_timeout: got s_rdy_o=0, expected 1 within 200 cycles");
    end else begin
      chk("lb_push", lb_push_o, e_push);
      chk("lb_pop", lb_pop_o, e_pop);
      chk("lb_eol", lb_eol_o, e_eol);
    end
    @(posedge clk);
    #1;
    s_vld_i = 1'b0; s_sof_i = 1'b0; s_eol_i = 1'b0; s_eof_i = 1'b0;
  endtask

  // row 0 may be w0 wide; stops before (ab_r, ab_c) without eof when ab_r >= 0
  task automatic send_frame(input int w0, input int w, input int h, input int base,
                            input int ab_r, input int ab_c);
    for (int r = 0; r < h; r++) begin
      int wr;
      wr = (r == 0) ? w0 : w;
      for (int c = 0; c < wr; c++) begin
        logic eol, eof, drop, frc;
        logic [LB_N-1:0] ps, pp;
        exp_t e;
        if (r == ab_r && c == ab_c) return;
        eol  = (c == wr - 1);
        eof  = eol && (r == h - 1);
        drop = (c >= MAXW);
        frc  = (c == MAXW - 1) && !eol;
        ps = '0;
        if (!drop) ps[r % LB_N] = 1'b1;
        pp = (!drop && r >= LB_N - 1) ? ~ps : '0;
        if (!drop && r >= LB_N - 1) begin
          for (int k = 0; k < LB_N; k++) e.dat[k] = px(base, r - (LB_N - 1) + k, c);
          e.sol = (c == 0);
          e.eol = eol | frc;
          e.eof = eof;
          sb.push_back(e);
        end
        send_px(px(base, r, c), (r == 0 && c == 0), eol, eof, ps, pp,
                !drop && (eol || frc), (r < LB_N - 2) && !(r == 0 && c == 0));
      end
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk(name, sb.size(), 0);
    chk({name, "_vld"}, m_vld_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    arst_n = 1'b0; s_vld_i = 1'b0; s_dat_i = '0; s_sof_i = 1'b0;
    s_eol_i = 1'b0; s_eof_i = 1'b0; lb_dat_i = '0; m_rdy_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_s_rdy", s_rdy_o, 1);
    chk("rst_m_vld", m_vld_o, 0);
    chk("rst_push_pop", {lb_push_o, lb_pop_o}, 0);
    chk("rst_sol_eol", {lb_sol_o, lb_eol_o}, 0);
    chk("rst_side_err", {m_sol_o, m_eol_o, m_eof_o, err_o}, 0);
    chk("rst_m_dat", 64'(m_dat_o), 0);
    @(posedge clk); #1;
    arst_n = 1'b1;

    send_px(8'h55, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    drain("idle_drop");

    send_frame(8, 8, 6, 0, -1, -1);
    drain("frame_8x6");

    send_frame(8, 8, 2, 8'h20, -1, -1);
    drain("short_frame");

    saw_stall = 1'b0;
    rdy_mode = 1;
    send_frame(8, 8, 6, 0, -1, -1);
    rdy_mode = 0;
    drain("backpressure");
    chk("credit_stall_seen", saw_stall, 1);

    send_frame(8, 8, 10, 0, -1, -1);
    drain("frame_10row");

    send_frame(8, 8, 6, 0, 4, 3);
    send_frame(8, 8, 6, 8'h40, -1, -1);
    drain("sof_abort");
    chk("abort_err", err_o, 0);

    send_frame(MAXW + 2, 8, 4, 0, -1, -1);
    drain("overflow");
    chk("overflow_err", err_o, 1);
    repeat (3) @(negedge clk);
    chk("overflow_err_sticky", err_o, 1);

    rdy_mode = 2;
    send_frame(8, 8, 6, 0, 3, 3);
    repeat (5) @(negedge clk);
    chk("prereset_vld", m_vld_o, 1);
    @(posedge clk); #1;
    arst_n = 1'b0;
    s_vld_i = 1'b1; s_sof_i = 1'b1; s_dat_i = 8'hAA;
    @(negedge clk);
    chk("inrst_m_vld", m_vld_o, 0);
    chk("inrst_s_rdy", s_rdy_o, 1);
    chk("inrst_push_pop", {lb_push_o, lb_pop_o}, 0);
    chk("inrst_err", err_o, 0);
    sb.delete();
    @(posedge clk); #1;
    s_vld_i = 1'b0; s_sof_i = 1'b0;
    arst_n = 1'b1;
    rdy_mode = 0;
    send_frame(8, 8, 6, 0, -1, -1);
    drain("post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
